// File: rtl/msk_rnd_bus_gen_pkg.sv
// Shared definitions for the masked-randomness generator: LFSR length, FSM encoding
// and the per-gadget fresh-randomness width helper.
package msk_rnd_bus_gen_pkg;

    localparam int LFSR_LEN = 127;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    // Fresh random bits one HPC2 AND gadget consumes per evaluation.
    function automatic int nrnd(input int d);
        return d * (d - 1) / 2;
    endfunction

endpackage

// File: rtl/msk_rnd_bus_gen_lfsr127_step.sv
// One unrolled step of the x^127 + x + 1 Fibonacci LFSR, producing W new bits at once.
module msk_rnd_bus_gen_lfsr127_step
    import msk_rnd_bus_gen_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [LFSR_LEN-1:0] s,
    output logic [LFSR_LEN-1:0] s_next
);

    logic [W-1:0] t;

    // W <= 126 keeps every feedback tap inside the current state, so no chaining is needed.
    assign t      = s[W-1:0] ^ s[W:1];
    assign s_next = {t, s[LFSR_LEN-1:W]};

endmodule

// File: rtl/msk_rnd_bus_gen.sv
// Seedable PRNG driving the rnd bus of a bank of masked HPC2 AND gadgets; output is
// withheld until a seed has been loaded and the LFSR has been warmed up.
module msk_rnd_bus_gen
    import msk_rnd_bus_gen_pkg::*;
#(
    parameter int d          = 2,
    parameter int N_AND      = 20,
    parameter int WARMUP_CYC = 128,
    localparam int RND_W     = N_AND * nrnd(d)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LFSR_LEN-1:0] seed_data,
    input  logic                seed_valid,
    output logic                seed_ready,
    input  logic                rnd_en,
    output logic [RND_W-1:0]    rnd,
    output logic                rnd_valid
);

    localparam int CNT_W = (WARMUP_CYC > 0) ? $clog2(WARMUP_CYC + 1) : 1;

    generate
        if (RND_W < 1 || RND_W > LFSR_LEN - 1) begin : g_bad_rnd_w
            $error("msk_rnd_bus_gen: RND_W must lie in 1..126");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [LFSR_LEN-1:0] s_q, s_d, s_step;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                seed_fire;

    msk_rnd_bus_gen_lfsr127_step #(.W(RND_W)) u_step (
        .s      (s_q),
        .s_next (s_step)
    );

    assign seed_ready = !rst && (state_q == IDLE || state_q == RUN);
    assign seed_fire  = seed_valid && seed_ready;
    assign rnd        = s_q[RND_W-1:0];
    assign rnd_valid  = (state_q == RUN);

    // A seed offered together with rnd_en wins: the new state is loaded unstepped.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RUN: begin
                if (seed_fire) begin
                    s_d     = (seed_data == '0) ? LFSR_LEN'(1) : seed_data;
                    cnt_d   = CNT_W'(WARMUP_CYC);
                    state_d = (WARMUP_CYC == 0) ? RUN : WARMUP;
                end else if (state_q == RUN && rnd_en) begin
                    s_d = s_step;
                end
            end
            WARMUP: begin
                s_d   = s_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_msk_rnd_bus_gen.sv
// Bench for msk_rnd_bus_gen: two instances (no warmup / 128-step warmup) on shared inputs,
// checked against hand-computed vectors and a bit-serial LFSR reference.
module tb_msk_rnd_bus_gen;
    import msk_rnd_bus_gen_pkg::*;

    localparam int D     = 2;
    localparam int N_AND = 4;
    localparam int RND_W = 4;

    typedef struct {
        logic [126:0] s;
        int           phase;
        int           cnt;
    } model_t;

    typedef struct {
        logic         r;
        logic         sv;
        logic [126:0] sd;
        logic         en;
        logic [3:0]   e_rnd;
        logic         e_valid;
        logic         e_ready;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         seed_valid;
    logic         rnd_en;
    logic [126:0] seed_data;
    logic         seed_ready0, rnd_valid0, seed_ready1, rnd_valid1;
    logic [3:0]   rnd0, rnd1;

    int n_checks = 0;
    int n_fail   = 0;

    model_t m0 = '{s: '0, phase: 0, cnt: 0};
    model_t m1 = '{s: '0, phase: 0, cnt: 0};

    msk_rnd_bus_gen #(.d(D), .N_AND(N_AND), .WARMUP_CYC(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .seed_data  (seed_data),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready0),
        .rnd_en     (rnd_en),
        .rnd        (rnd0),
        .rnd_valid  (rnd_valid0)
    );

    msk_rnd_bus_gen #(.d(D), .N_AND(N_AND), .WARMUP_CYC(128)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .seed_data  (seed_data),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready1),
        .rnd_en     (rnd_en),
        .rnd        (rnd1),
        .rnd_valid  (rnd_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: shifts one bit at a time, RND_W times per step.
    function automatic logic [126:0] serial_step(input logic [126:0] s_in);
        logic [126:0] s;
        s = s_in;
        for (int i = 0; i < RND_W; i++) begin
            s = {s[0] ^ s[1], s[126:1]};
        end
        return s;
    endfunction

    function automatic logic [126:0] golden_after(input logic [126:0] seed, input int steps);
        logic [126:0] s;
        s = seed;
        for (int i = 0; i < steps; i++) begin
            s = serial_step(s);
        end
        return s;
    endfunction

    function automatic model_t model_next(input model_t m, input int wc, input logic r,
                                          input logic sv, input logic [126:0] sd,
                                          input logic en);
        model_t n;
        n = m;
        if (r) begin
            n.s     = '0;
            n.phase = 0;
            n.cnt   = 0;
        end else if (m.phase == 1) begin
            n.s   = serial_step(m.s);
            n.cnt = m.cnt - 1;
            if (m.cnt == 1) n.phase = 2;
        end else if (sv) begin
            n.s     = (sd == '0) ? 127'h1 : sd;
            n.cnt   = wc;
            n.phase = (wc == 0) ? 2 : 1;
        end else if (m.phase == 2 && en) begin
            n.s = serial_step(m.s);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= model_next(m0, 0, rst, seed_valid, seed_data, rnd_en);
        m1 <= model_next(m1, 128, rst, seed_valid, seed_data, rnd_en);
    end

    task automatic applyStimulus(input logic r, input logic sv, input logic [126:0] sd,
                                 input logic en);
        rst        = r;
        seed_valid = sv;
        seed_data  = sd;
        rnd_en     = en;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_models(input string tag);
        checkOutput({tag, "/rnd0"},   32'(rnd0),        32'(m0.s[3:0]));
        checkOutput({tag, "/valid0"}, 32'(rnd_valid0),  32'(m0.phase == 2));
        checkOutput({tag, "/ready0"}, 32'(seed_ready0), 32'(!rst && m0.phase != 1));
        checkOutput({tag, "/rnd1"},   32'(rnd1),        32'(m1.s[3:0]));
        checkOutput({tag, "/valid1"}, 32'(rnd_valid1),  32'(m1.phase == 2));
        checkOutput({tag, "/ready1"}, 32'(seed_ready1), 32'(!rst && m1.phase != 1));
    endtask

    vec_t         vecs[7];
    logic [126:0] seed_x, seed_y, g, rnd_hold_seed;
    logic [127:0] r128;

    initial begin
        seed_x = {63'h1A3B1C2D9E8F7061, 64'h524334251607F8E9};
        seed_y = {63'h0123456789ABCDEF, 64'hFEDCBA9876543215};

        // Reset/idle and the seed-1 known vector on the no-warmup instance.
        vecs[0] = '{1'b1, 1'b0, 127'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 127'h0, 1'b1, 4'h0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 127'h0, 1'b1, 4'h0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 127'h1, 1'b0, 4'h0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 127'h0, 1'b1, 4'h1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 127'h0, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 127'h0, 1'b0, 4'h0, 1'b1, 1'b1};

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].r, vecs[i].sv, vecs[i].sd, vecs[i].en);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_rnd", i),   32'(rnd0),        32'(vecs[i].e_rnd));
            checkOutput($sformatf("vec%0d_valid", i), 32'(rnd_valid0),  32'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d_ready", i), 32'(seed_ready0), 32'(vecs[i].e_ready));
            tick();
        end

        // One step already taken; 30 more make 31, moving the seed bit down to rnd[3].
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("known_31_steps", 32'(rnd0), 32'h8);
        check_models("known");
        tick();

        // Zero seed must replay the seed-1 sequence.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        tick();
        g = 127'h1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("zero_seed_step%0d", i), 32'(rnd0), 32'(g[3:0]));
            g = serial_step(g);
            tick();
        end

        // Warmup: seed_valid held with another seed must be ignored while warming up.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, seed_x, 1'b0);
        @(negedge clk);
        checkOutput("warm_accept_ready", 32'(seed_ready1), 32'h1);
        tick();
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1'b0, i < 127, seed_y, 1'($urandom_range(0, 1)));
            @(negedge clk);
            checkOutput($sformatf("warm_valid_c%0d", i), 32'(rnd_valid1),  32'h0);
            checkOutput($sformatf("warm_ready_c%0d", i), 32'(seed_ready1), 32'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        g = golden_after(seed_x, 128);
        checkOutput("warm_done_valid", 32'(rnd_valid1), 32'h1);
        checkOutput("warm_done_rnd",   32'(rnd1),       32'(g[3:0]));
        check_models("warm");
        tick();

        // Reseed collision with rnd_en in RUN: seed loads unstepped.
        applyStimulus(1'b0, 1'b1, seed_y, 1'b1);
        @(negedge clk);
        checkOutput("coll_ready1", 32'(seed_ready1), 32'h1);
        checkOutput("coll_valid1", 32'(rnd_valid1),  32'h1);
        tick();
        rnd_hold_seed = seed_y;
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1'b0, 1'b0, '0, (i < 10) ? 1'b0 : 1'($urandom_range(0, 1)));
            @(negedge clk);
            checkOutput($sformatf("coll_warm_valid_c%0d", i), 32'(rnd_valid1), 32'h0);
            if (i < 10) begin
                checkOutput($sformatf("coll_stall_rnd0_c%0d", i), 32'(rnd0),
                            32'(rnd_hold_seed[3:0]));
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        g = golden_after(seed_y, 128);
        checkOutput("coll_done_valid", 32'(rnd_valid1), 32'h1);
        checkOutput("coll_done_rnd",   32'(rnd1),       32'(g[3:0]));
        tick();

        // Reset mid-WARMUP (dut1) and mid-RUN (dut0); the seed offered alongside is lost.
        applyStimulus(1'b0, 1'b1, seed_x, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 1'b1, seed_y, 1'b1);
        @(negedge clk);
        checkOutput("midrst_ready0_during", 32'(seed_ready0), 32'h0);
        checkOutput("midrst_ready1_during", 32'(seed_ready1), 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("midrst_rnd0",   32'(rnd0),        32'h0);
        checkOutput("midrst_valid0", 32'(rnd_valid0),  32'h0);
        checkOutput("midrst_ready0", 32'(seed_ready0), 32'h1);
        checkOutput("midrst_rnd1",   32'(rnd1),        32'h0);
        checkOutput("midrst_valid1", 32'(rnd_valid1),  32'h0);
        checkOutput("midrst_ready1", 32'(seed_ready1), 32'h1);
        tick();

        // Random soak against the reference model.
        for (int c = 0; c < 10000; c++) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom_range(0, 999) == 0,
                          $urandom_range(0, 149) == 0,
                          ($urandom_range(0, 7) == 0) ? 127'h0 : r128[126:0],
                          $urandom_range(0, 3) != 0);
            @(negedge clk);
            check_models($sformatf("soak%0d", c));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
